// File: rtl/cpx2real_pkg.sv
// Shared widths, carrier phase encodings, saturation limits and the mixer/saturator
// helper for the complex-to-real up-converter.
package cpx2real_pkg;

    localparam int CPX_W  = 13;
    localparam int REAL_W = 12;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

    localparam logic signed [13:0] SAT_MAX = 14'sd2047;
    localparam logic signed [13:0] SAT_MIN = -14'sd2048;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [CPX_W-1:0] re;
        logic [CPX_W-1:0] im;
    } cpx_t;

    // fs/4 carrier: 0 -> +re, 1 -> -im, 2 -> -re, 3 -> +im, then clamp to 12 bits.
    function automatic logic [REAL_W-1:0] mix_sample(input cpx_t s, input logic [1:0] ph,
                                                    input logic offset_bin);
        logic signed [13:0] v;
        logic [REAL_W-1:0]  r;
        case (ph)
            PH_0:    v =  signed'({s.re[CPX_W-1], s.re});
            PH_1:    v = -signed'({s.im[CPX_W-1], s.im});
            PH_2:    v = -signed'({s.re[CPX_W-1], s.re});
            default: v =  signed'({s.im[CPX_W-1], s.im});
        endcase
        if (v > SAT_MAX)      r = SAT_MAX[REAL_W-1:0];
        else if (v < SAT_MIN) r = SAT_MIN[REAL_W-1:0];
        else                  r = v[REAL_W-1:0];
        if (offset_bin) r[REAL_W-1] = ~r[REAL_W-1];
        return r;
    endfunction

endpackage

// File: rtl/cpx2real_cpx_fifo.sv
// Synchronous FIFO of complex samples; head is visible combinationally, a push
// into a full FIFO lands only when a pop frees a slot in the same cycle.
module cpx_fifo
    import cpx2real_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  cpx_t wr_data,
    output cpx_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cpx_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/cpx2real.sv
// TX up-converter: buffers complex samples, repeats each UPS times against an fs/4
// carrier and emits registered 12-bit real samples paced by dac_req.
module cpx2real
    import cpx2real_pkg::*;
#(
    parameter int UPS        = 4,
    parameter int DEPTH      = 4,
    parameter bit OFFSET_BIN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_rdy,
    input  logic [CPX_W-1:0]  re,
    input  logic [CPX_W-1:0]  im,
    input  logic              dac_req,
    input  logic              clr_flags,
    output logic [REAL_W-1:0] x_tx,
    output logic              tx_rdy,
    output logic              fifo_full,
    output logic              ovf,
    output logic              unf,
    output state_t            state_dbg
);

    localparam logic [3:0] REP_LAST = 4'(UPS - 1);

    state_t     state, state_nxt;
    cpx_t       head, cur, s1_smp;
    logic       fifo_empty;
    logic       pop, rep_clr, rep_inc, under;
    logic [3:0] rep;
    logic [1:0] phase, s1_phase;
    logic       s1_vld, s1_under;

    cpx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (data_rdy),
        .pop     (pop),
        .wr_data ({re, im}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (dac_req) begin
            if (state == ST_EMPTY && !fifo_empty)
                state_nxt = ST_ACTIVE;
            else if (state == ST_ACTIVE && rep == REP_LAST && fifo_empty)
                state_nxt = ST_EMPTY;
        end
    end

    always_comb begin
        pop     = 1'b0;
        rep_clr = 1'b0;
        rep_inc = 1'b0;
        under   = 1'b0;
        if (dac_req) begin
            if (state == ST_ACTIVE && rep != REP_LAST) begin
                rep_inc = 1'b1;
            end else if (!fifo_empty) begin
                pop     = 1'b1;
                rep_clr = 1'b1;
            end else begin
                under   = 1'b1;
            end
        end
    end

    assign state_dbg = state;

    // Stage 1: sample selection and carrier phase; the phase runs on every request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur      <= '0;
            rep      <= '0;
            phase    <= PH_0;
            s1_vld   <= 1'b0;
            s1_under <= 1'b0;
            s1_smp   <= '0;
            s1_phase <= PH_0;
        end else begin
            if (pop)          cur <= head;
            if (rep_clr)      rep <= '0;
            else if (rep_inc) rep <= rep + 1'b1;
            if (dac_req)      phase <= phase + 1'b1;
            s1_vld   <= dac_req;
            s1_under <= under;
            s1_smp   <= pop ? head : cur;
            s1_phase <= phase;
        end
    end

    // Stage 2: mix, saturate and register the DAC word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_tx   <= '0;
            tx_rdy <= 1'b0;
        end else begin
            tx_rdy <= s1_vld;
            if (s1_vld) x_tx <= s1_under ? '0 : mix_sample(s1_smp, s1_phase, OFFSET_BIN);
        end
    end

    // A new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (ovf & ~clr_flags) | (data_rdy & fifo_full & ~pop);
            unf <= (unf & ~clr_flags) | under;
        end
    end

endmodule
